spi_reg_sched: RTL and testbench

//  Schedules all accesses to the shared single-port SPI register bank in the clk_32m domain.
//  Two requesters share the bank: the SPI slave (we/re strobes crossing from the SPI clock)
//  and one internal fabric requester. The block synchronizes and one-shots the SPI strobes,

---
 rtl/spi_reg_sched.sv | 155 +++++++++++++++
 tb/tb_spi_reg_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_sched.sv
// Arbiter and sequencer for the shared single-port SPI register bank (clk_32m domain).
// SPI strobes are synchronized and one-shot into single-entry read/write slots; SPI wins over the internal port.
module spi_reg_sched #(
  parameter int DSZ    = 32,
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           spi_we,
  input  logic           spi_re,
  input  logic [AW-1:0]  spi_addr,
  input  logic [DSZ-1:0] spi_wdat,
  output logic [DSZ-1:0] spi_rdat,
  input  logic           int_req,
  input  logic           int_wr,
  input  logic [AW-1:0]  int_addr,
  input  logic [DSZ-1:0] int_wdat,
  output logic           int_gnt,
  output logic           int_done,
  output logic [DSZ-1:0] int_rdat,
  output logic           bank_en,
  output logic           bank_we,
  output logic [AW-1:0]  bank_addr,
  output logic [DSZ-1:0] bank_wdat,
  input  logic [DSZ-1:0] bank_rdat,
  output logic [DSZ-1:0] rd_count,
  output logic           busy,
  output logic           ovr
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;

  state_t         state;
  logic [2:0]     we_sy, re_sy;
  logic           we_pls, re_pls;
  logic           wr_pend, rd_pend;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [DSZ-1:0] wr_dat;
  logic           acc_int, acc_wr;
  logic [CW-1:0]  cnt;

  assign we_pls = we_sy[1] & ~we_sy[2];
  assign re_pls = re_sy[1] & ~re_sy[2];
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_sy     <= '0;
      re_sy     <= '0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      wr_dat    <= '0;
      acc_int   <= 1'b0;
      acc_wr    <= 1'b0;
      cnt       <= '0;
      spi_rdat  <= '0;
      int_gnt   <= 1'b0;
      int_done  <= 1'b0;
      int_rdat  <= '0;
      bank_en   <= 1'b0;
      bank_we   <= 1'b0;
      bank_addr <= '0;
      bank_wdat <= '0;
      rd_count  <= '0;
      ovr       <= 1'b0;
    end else begin
      we_sy    <= {we_sy[1:0], spi_we};
      re_sy    <= {re_sy[1:0], spi_re};
      bank_en  <= 1'b0;
      bank_we  <= 1'b0;
      int_gnt  <= 1'b0;
      int_done <= 1'b0;

      // A strobe landing on an occupied slot is dropped, slot untouched.
      if (we_pls) begin
        if (wr_pend) ovr <= 1'b1;
        else begin
          wr_pend <= 1'b1;
          wr_addr <= spi_addr;
          wr_dat  <= spi_wdat;
        end
      end
      if (re_pls) begin
        if (rd_pend) ovr <= 1'b1;
        else begin
          rd_pend <= 1'b1;
          rd_addr <= spi_addr;
        end
      end

      case (state)
        IDLE: begin
          if (rd_pend) begin
            state     <= ACC;
            bank_en   <= 1'b1;
            bank_addr <= rd_addr;
            acc_int   <= 1'b0;
            acc_wr    <= 1'b0;
          end else if (wr_pend) begin
            state     <= ACC;
            bank_en   <= 1'b1;
            bank_we   <= 1'b1;
            bank_addr <= wr_addr;
            bank_wdat <= wr_dat;
            acc_int   <= 1'b0;
            acc_wr    <= 1'b1;
          end else if (int_req && !int_done) begin
            // int_req is still high during the done cycle; don't re-grant it.
            state     <= ACC;
            bank_en   <= 1'b1;
            bank_we   <= int_wr;
            bank_addr <= int_addr;
            if (int_wr) bank_wdat <= int_wdat;
            int_gnt   <= 1'b1;
            acc_int   <= 1'b1;
            acc_wr    <= int_wr;
          end
        end
        ACC: begin
          if (acc_wr) begin
            state <= IDLE;
            if (acc_int) int_done <= 1'b1;
            else         wr_pend  <= 1'b0;
          end else begin
            state <= WAIT;
            cnt   <= CW'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
            if (acc_int) begin
              int_rdat <= bank_rdat;
              int_done <= 1'b1;
            end else begin
              spi_rdat <= bank_rdat;
              rd_count <= rd_count + DSZ'(1);
              rd_pend  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_sched.sv
// Directed bench for spi_reg_sched: bank accesses, SPI read data and internal read data
// are checked against scoreboard queues filled when the stimulus is driven.
module tb_spi_reg_sched;
  localparam int DSZ    = 32;
  localparam int AW     = 7;
  localparam int RD_LAT = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           spi_we = 1'b0, spi_re = 1'b0;
  logic [AW-1:0]  spi_addr = '0;
  logic [DSZ-1:0] spi_wdat = '0;
  logic [DSZ-1:0] spi_rdat;
  logic           int_req = 1'b0, int_wr = 1'b0;
  logic [AW-1:0]  int_addr = '0;
  logic [DSZ-1:0] int_wdat = '0;
  logic           int_gnt, int_done;
  logic [DSZ-1:0] int_rdat;
  logic           bank_en, bank_we;
  logic [AW-1:0]  bank_addr;
  logic [DSZ-1:0] bank_wdat, bank_rdat;
  logic [DSZ-1:0] rd_count;
  logic           busy, ovr;

  spi_reg_sched #(.DSZ(DSZ), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .spi_we(spi_we), .spi_re(spi_re), .spi_addr(spi_addr), .spi_wdat(spi_wdat), .spi_rdat(spi_rdat),
    .int_req(int_req), .int_wr(int_wr), .int_addr(int_addr), .int_wdat(int_wdat),
    .int_gnt(int_gnt), .int_done(int_done), .int_rdat(int_rdat),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdat(bank_wdat),
    .bank_rdat(bank_rdat), .rd_count(rd_count), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [AW-1:0] addr; logic [DSZ-1:0] wdat;} acc_t;
  typedef struct {logic rd; logic [DSZ-1:0] d;} iexp_t;

  acc_t           exp_bank[$];
  logic [DSZ-1:0] exp_spi[$];
  iexp_t          exp_int[$];
  int             n_chk = 0, n_fail = 0;
  logic [DSZ-1:0] mem [128];
  logic [DSZ-1:0] shadow [128];
  logic [DSZ-1:0] rpipe [RD_LAT];
  logic [RD_LAT-1:0] rvld = '0;
  logic [DSZ-1:0] prev_cnt = '0, exp_cnt;
  logic           skip_cnt = 1'b0;
  acc_t           e_acc;
  iexp_t          e_int;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bank model: data appears RD_LAT cycles after bank_en, garbage otherwise
  always @(posedge clk) begin
    if (bank_en && bank_we) mem[bank_addr] <= bank_wdat;
    rpipe[0] <= mem[bank_addr];
    rvld[0]  <= bank_en && !bank_we;
    for (int i = 1; i < RD_LAT; i++) begin
      rpipe[i] <= rpipe[i-1];
      rvld[i]  <= rvld[i-1];
    end
  end
  assign bank_rdat = rvld[RD_LAT-1] ? rpipe[RD_LAT-1] : 32'hBAD0BAD0;

  // scoreboard monitors
  always @(negedge clk) begin
    if (reset) prev_cnt = '0;
    else begin
      if (bank_en) begin
        if (exp_bank.size() == 0) chk("bank_unexpected", 1, 0);
        else begin
          e_acc = exp_bank.pop_front();
          chk("bank_we", bank_we, e_acc.we);
          chk("bank_addr", bank_addr, e_acc.addr);
          if (e_acc.we) chk("bank_wdat", bank_wdat, e_acc.wdat);
        end
      end
      if (rd_count !== prev_cnt) begin
        if (!skip_cnt) begin
          exp_cnt = prev_cnt + 32'd1;
          chk("rd_count_step", rd_count, exp_cnt);
          if (exp_spi.size() == 0) chk("spi_rd_unexpected", 1, 0);
          else chk("spi_rdat", spi_rdat, exp_spi.pop_front());
        end
        prev_cnt = rd_count;
      end
      if (int_done) begin
        if (exp_int.size() == 0) chk("int_done_unexpected", 1, 0);
        else begin
          e_int = exp_int.pop_front();
          if (e_int.rd) chk("int_rdat", int_rdat, e_int.d);
        end
      end
    end
  end

  task automatic spi_rd(input logic [AW-1:0] a, input int hi);
    exp_bank.push_back('{1'b0, a, '0});
    exp_spi.push_back(shadow[a]);
    spi_addr = a;
    spi_re   = 1'b1;
    repeat (hi) @(negedge clk);
    spi_re   = 1'b0;
  endtask

  task automatic wait_cnt(input logic [DSZ-1:0] tgt);
    for (int i = 0; i < 60 && rd_count !== tgt; i++) @(negedge clk);
    chk("rd_count_reach", rd_count, tgt);
  endtask

  int gnt_c, done_c, rdc_c, n_gnt;
  logic [DSZ-1:0] cnt0;

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]    = 32'hA5000000 | i;
      shadow[i] = 32'hA5000000 | i;
    end
    repeat (3) @(negedge clk);
    chk("rst_bank_en", bank_en, 0);
    chk("rst_bank_we", bank_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_spi_rdat", spi_rdat, 0);
    chk("rst_int_gnt", int_gnt, 0);
    chk("rst_int_done", int_done, 0);
    chk("rst_bank_addr", bank_addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset during WAIT abandons the read
    exp_bank.push_back('{1'b0, 7'h10, '0});
    spi_addr = 7'h10; spi_re = 1'b1;
    repeat (2) @(negedge clk);
    spi_re = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_busy_in_wait", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_bank_en", bank_en, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_rd_count", rd_count, 0);
    chk("t1_rst_spi_rdat", spi_rdat, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("t1_rd_count_after", rd_count, 0);
    chk("t1_idle_after", busy, 0);
    chk("t1_bank_q", exp_bank.size(), 0);

    // SPI write, bank strobe 4 clk after strobe rise
    spi_addr = 7'h7D; spi_wdat = 32'h000061A8;
    exp_bank.push_back('{1'b1, 7'h7D, 32'h000061A8});
    shadow[7'h7D] = 32'h000061A8;
    spi_we = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) spi_we = 1'b0;
      if (c == 3) chk("t2_en_early", bank_en, 0);
      if (c == 4) begin
        chk("t2_bank_en", bank_en, 1);
        chk("t2_bank_we", bank_we, 1);
      end
      if (c == 5) begin
        chk("t2_en_one_cycle", bank_en, 0);
        chk("t2_we_low", bank_we, 0);
        chk("t2_addr_hold", bank_addr, 7'h7D);
      end
    end
    spi_rd(7'h7D, 2);
    wait_cnt(1);
    chk("t2_spi_rdat", spi_rdat, 32'h000061A8);

    // internal write: gnt then done next cycle
    int_wr = 1'b1; int_addr = 7'h60; int_wdat = 32'h12345678;
    exp_bank.push_back('{1'b1, 7'h60, 32'h12345678});
    exp_int.push_back('{1'b0, '0});
    shadow[7'h60] = 32'h12345678;
    int_req = 1'b1;
    gnt_c = -1; done_c = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (int_gnt) gnt_c = c;
      if (int_done) begin done_c = c; int_req = 1'b0; end
    end
    chk("iw_gnt_cycle", gnt_c, 1);
    chk("iw_done_cycle", done_c, 2);
    spi_rd(7'h60, 2);
    wait_cnt(2);

    // SPI read and internal read visible in the same IDLE cycle
    exp_bank.push_back('{1'b0, 7'h33, '0});
    exp_spi.push_back(shadow[7'h33]);
    exp_bank.push_back('{1'b0, 7'h22, '0});
    exp_int.push_back('{1'b1, shadow[7'h22]});
    cnt0 = rd_count;
    gnt_c = -1; done_c = -1; rdc_c = -1; n_gnt = 0;
    spi_addr = 7'h33; spi_re = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 2) spi_re = 1'b0;
      if (c == 3) begin int_wr = 1'b0; int_addr = 7'h22; int_req = 1'b1; end
      if (c == 4) begin
        chk("t3_spi_first_en", bank_en, 1);
        chk("t3_spi_first_gnt", int_gnt, 0);
      end
      if (int_gnt) begin n_gnt++; if (gnt_c < 0) gnt_c = c; end
      if (int_done) begin done_c = c; int_req = 1'b0; end
      if (rd_count !== cnt0 && rdc_c < 0) rdc_c = c;
    end
    chk("t3_spi_done_cycle", rdc_c, 4 + RD_LAT + 1);
    chk("t3_gnt_after_spi", gnt_c, rdc_c + 1);
    chk("t3_done_lat", done_c - rdc_c, 2 + RD_LAT);
    chk("t3_one_gnt", n_gnt, 1);

    // overrun: second spi_re while rd_pend waits behind an internal read
    exp_bank.push_back('{1'b0, 7'h55, '0});
    exp_int.push_back('{1'b1, shadow[7'h55]});
    exp_bank.push_back('{1'b0, 7'h44, '0});
    exp_spi.push_back(shadow[7'h44]);
    cnt0 = rd_count;
    spi_addr = 7'h44; spi_re = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin int_wr = 1'b0; int_addr = 7'h55; int_req = 1'b1; end
      if (c == 2) spi_re = 1'b0;
      if (c == 3) begin spi_addr = 7'h46; spi_re = 1'b1; end
      if (c == 5) begin chk("t4_ovr_before", ovr, 0); spi_re = 1'b0; end
      if (c == 6) chk("t4_ovr_set", ovr, 1);
      if (int_done) int_req = 1'b0;
    end
    wait_cnt(cnt0 + 32'd1);
    chk("t4_ovr_sticky", ovr, 1);

    // rd_count wrap
    skip_cnt = 1'b1;
    force dut.rd_count = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.rd_count;
    @(negedge clk);
    skip_cnt = 1'b0;
    spi_rd(7'h01, 2);
    wait_cnt(32'h0);

    // long strobe gives one access
    spi_rd(7'h02, 10);
    repeat (12) @(negedge clk);
    chk("t6_rd_count", rd_count, 1);
    chk("t6_spi_rdat", spi_rdat, shadow[7'h02]);
    chk("bank_q_empty", exp_bank.size(), 0);
    chk("spi_q_empty", exp_spi.size(), 0);
    chk("int_q_empty", exp_int.size(), 0);
    chk("ovr_still_set", ovr, 1);

    #2 reset = 1'b1;
    #1;
    chk("final_rst_ovr", ovr, 0);
    chk("final_rst_rd_count", rd_count, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
